// File: rtl/divider_arbiter.sv
// Round-robin sharing of one divider between NUM_REQ requesters; optional watchdog under DIV_ARB_TIMEOUT_EN.
// Latency: accept -> div_valid_out 2 cycles later; div_done_in -> rsp_valid_out 1 cycle later.
// Backpressure: one-deep slot per requester, ready = slot empty; issue stalls while div_busy_in.
module divider_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [NUM_REQ-1:0]         req_valid_in,
    output logic [NUM_REQ-1:0]         req_ready_out,
    input  logic [NUM_REQ*WIDTH-1:0]   req_dividend_in,
    input  logic [NUM_REQ*WIDTH-1:0]   req_divisor_in,
    output logic [NUM_REQ-1:0]         rsp_valid_out,
    output logic [WIDTH-1:0]           rsp_quotient_out,
    output logic [WIDTH-1:0]           rsp_remainder_out,
    output logic                       rsp_error_out,
    output logic [WIDTH-1:0]           div_dividend_out,
    output logic [WIDTH-1:0]           div_divisor_out,
    output logic                       div_valid_out,
    input  logic [WIDTH-1:0]           div_quotient_in,
    input  logic [WIDTH-1:0]           div_remainder_in,
    input  logic                       div_done_in,
    input  logic                       div_error_in,
    input  logic                       div_busy_in,
    output logic                       div_abort_out
);

    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT < 1) begin : g_bad_cfg
        $error("divider_arbiter: illegal parameter value");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   slot_full_q, slot_full_d;
    logic [WIDTH-1:0]     slot_dvd_q [NUM_REQ];
    logic [WIDTH-1:0]     slot_dvd_d [NUM_REQ];
    logic [WIDTH-1:0]     slot_dvs_q [NUM_REQ];
    logic [WIDTH-1:0]     slot_dvs_d [NUM_REQ];
    logic [IW-1:0]        winner_q, winner_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]     div_dvd_q, div_dvd_d;
    logic [WIDTH-1:0]     div_dvs_q, div_dvs_d;
    logic                 div_valid_q, div_valid_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]     rsp_quot_q, rsp_quot_d;
    logic [WIDTH-1:0]     rsp_rem_q, rsp_rem_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 abort_q, abort_d;
    logic                 release_slot;

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
`endif

    // First full slot at or after rr_ptr, searching cyclically.
    logic                 pick_vld;
    logic [IW-1:0]        pick_idx;
    logic [IW:0]          cand;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_REQ)) begin
                cand = cand - (IW+1)'(NUM_REQ);
            end
            if (!pick_vld && slot_full_q[cand[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        slot_full_d  = slot_full_q;
        slot_dvd_d   = slot_dvd_q;
        slot_dvs_d   = slot_dvs_q;
        winner_d     = winner_q;
        rr_ptr_d     = rr_ptr_q;
        div_dvd_d    = div_dvd_q;
        div_dvs_d    = div_dvs_q;
        div_valid_d  = 1'b0;
        rsp_valid_d  = '0;
        rsp_quot_d   = rsp_quot_q;
        rsp_rem_d    = rsp_rem_q;
        rsp_err_d    = rsp_err_q;
        abort_d      = 1'b0;
        release_slot = 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif

        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid_in[i] && !slot_full_q[i]) begin
                slot_full_d[i] = 1'b1;
                slot_dvd_d[i]  = req_dividend_in[i*WIDTH +: WIDTH];
                slot_dvs_d[i]  = req_divisor_in[i*WIDTH +: WIDTH];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    winner_d  = pick_idx;
                    div_dvd_d = slot_dvd_q[pick_idx];
                    div_dvs_d = slot_dvs_q[pick_idx];
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!div_busy_in) begin
                    div_valid_d = 1'b1;
                    state_d     = ST_WAIT;
`ifdef DIV_ARB_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end
            end
            ST_WAIT: begin
                // A real completion wins over a watchdog expiry in the same cycle.
                if (div_done_in) begin
                    rsp_quot_d   = div_quotient_in;
                    rsp_rem_d    = div_remainder_in;
                    rsp_err_d    = div_error_in;
                    release_slot = 1'b1;
                end
`ifdef DIV_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    rsp_quot_d   = '0;
                    rsp_rem_d    = '0;
                    rsp_err_d    = 1'b1;
                    abort_d      = 1'b1;
                    release_slot = 1'b1;
                end else begin
                    tmo_cnt_d    = tmo_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        if (release_slot) begin
            rsp_valid_d[winner_q] = 1'b1;
            slot_full_d[winner_q] = 1'b0;
            rr_ptr_d = (winner_q == IW'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
            state_d  = ST_IDLE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            slot_full_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_dvd_q[i] <= '0;
                slot_dvs_q[i] <= '0;
            end
            winner_q    <= '0;
            rr_ptr_q    <= '0;
            div_dvd_q   <= '0;
            div_dvs_q   <= '0;
            div_valid_q <= 1'b0;
            rsp_valid_q <= '0;
            rsp_quot_q  <= '0;
            rsp_rem_q   <= '0;
            rsp_err_q   <= 1'b0;
            abort_q     <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            slot_full_q <= slot_full_d;
            slot_dvd_q  <= slot_dvd_d;
            slot_dvs_q  <= slot_dvs_d;
            winner_q    <= winner_d;
            rr_ptr_q    <= rr_ptr_d;
            div_dvd_q   <= div_dvd_d;
            div_dvs_q   <= div_dvs_d;
            div_valid_q <= div_valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_quot_q  <= rsp_quot_d;
            rsp_rem_q   <= rsp_rem_d;
            rsp_err_q   <= rsp_err_d;
            abort_q     <= abort_d;
`ifdef DIV_ARB_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign req_ready_out     = ~slot_full_q;
    assign rsp_valid_out     = rsp_valid_q;
    assign rsp_quotient_out  = rsp_quot_q;
    assign rsp_remainder_out = rsp_rem_q;
    assign rsp_error_out     = rsp_err_q;
    assign div_dividend_out  = div_dvd_q;
    assign div_divisor_out   = div_dvs_q;
    assign div_valid_out     = div_valid_q;
`ifdef DIV_ARB_TIMEOUT_EN
    assign div_abort_out     = abort_q;
`else
    assign div_abort_out     = 1'b0;
`endif

endmodule

// File: doc/divider_arbiter.md
# divider_arbiter

- Shares one `divider` instance between `NUM_REQ` requesters, e.g. the x and y averages of the centroid path, so only one divider is synthesized.
- Each requester gets a one-deep request slot and a valid/ready handshake.
- A round-robin scheduler issues one division at a time to the divider and routes the quotient, remainder and error flag back to the originating requester.
- Sits between the accumulation logic and the shared divider in the motion-gate pipeline.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters; legal range 2..4.
- `WIDTH`, 32: width of dividend, divisor, quotient and remainder.
- `TIMEOUT`, 64: watchdog limit in cycles. Used only when `DIV_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk_in` input 1: system clock. Only one clock; all logic on its rising edge.
- `rst_in` input 1: synchronous, active-high reset.
- `req_valid_in` input NUM_REQ: per-requester request strobe.
- `req_ready_out` output NUM_REQ: slot i empty; request accepted when valid & ready.
- `req_dividend_in` input NUM_REQ*WIDTH: flat bus; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_divisor_in` input NUM_REQ*WIDTH: flat bus, same packing as the dividend.
- `rsp_valid_out` output NUM_REQ: one-hot, one-cycle pulse; result belongs to that requester.
- `rsp_quotient_out` output WIDTH: shared result bus; valid while `rsp_valid_out` is nonzero.
- `rsp_remainder_out` output WIDTH: shared result bus, same validity.
- `rsp_error_out` output 1: error from the divider, or a timeout.
- `div_dividend_out` output WIDTH: connects to the divider `dividend_in`.
- `div_divisor_out` output WIDTH: connects to the divider `divisor_in`.
- `div_valid_out` output 1: connects to the divider `data_valid_in`; one-cycle pulse.
- `div_quotient_in`, `div_remainder_in` input WIDTH: from the divider.
- `div_done_in` input 1: divider `data_valid_out`.
- `div_error_in` input 1: divider `error_out`.
- `div_busy_in` input 1: divider `busy_out`.
- `div_abort_out` output 1: one-cycle pulse; the top level ORs it into the divider reset.

## Operation
- **Slots.** Each requester has a slot holding dividend and divisor.
  - `req_ready_out[i] = !slot_full[i]`; this is combinational from the slot register only.
  - On acceptance, the slot captures both operands.
  - A slot is cleared on the cycle its response is emitted.
  - There is no bypass: after a release, a new request for the same slot is accepted one cycle later.
- **FSM states:** IDLE, ISSUE, WAIT.
  - IDLE → ISSUE when any slot is full. The winner is the first full slot at or after `rr_ptr`, searching cyclically. The winner's index and operands are registered to `div_dividend_out` and `div_divisor_out`.
  - ISSUE: if `div_busy_in` is 0, assert `div_valid_out` for exactly one cycle and go to WAIT. Otherwise stay in ISSUE, holding the operands.
  - WAIT: on `div_done_in`, register the quotient, remainder and `div_error_in`. Pulse `rsp_valid_out[winner]` on the next cycle, clear the slot, set `rr_ptr = winner+1 mod NUM_REQ`, and return to IDLE.
- `div_done_in` is ignored outside WAIT.
- **Divisor = 0** is forwarded unchanged; the divider's error is reported on `rsp_error_out`, and the quotient and remainder are passed through as returned.
- Requests can be accepted in any state, including for non-winning slots while the divider is in use.
- **Reset values:** all slots empty, `req_ready_out` all 1, state IDLE, `rr_ptr` 0, all `rsp_*` and `div_*` outputs 0.
  - Reset mid-operation drops the outstanding division; no response is emitted for it.

## Timing
- Request accepted at edge k → slot full after k → ISSUE after k+1 → `div_valid_out` high during cycle k+2 (when the divider is not busy).
- Response: `div_done_in` sampled at edge m → `rsp_valid_out` high during the cycle after m.
- The earliest next issue is 2 cycles after a response: IDLE then ISSUE.
- Only one division is outstanding at any time.
- With all slots continuously full, grants rotate strictly 0, 1, …, NUM_REQ-1, 0.

## Configuration
- Macro `DIV_ARB_TIMEOUT_EN`.
  - **Defined:** a counter runs while in WAIT. When it reaches `TIMEOUT` cycles without `div_done_in`:
    - emit a response for the winner with `rsp_error_out`=1 and quotient/remainder 0;
    - pulse `div_abort_out` for one cycle;
    - clear the slot, advance `rr_ptr`, go to IDLE.
    - A `div_done_in` arriving in that same cycle takes priority: a normal response, no abort.
  - **Undefined:** no counter; WAIT can last indefinitely; `div_abort_out` is tied to 0.

## Test plan
- **Single request.** Requester 0 sends 1000/8 → one pulse of `rsp_valid_out`=01 with quotient 125, remainder 0, error 0. The slot is ready again the following cycle.
- **Simultaneous requests.** Both requesters assert at once: 9600/40 (r0) and 6400/40 (r1) → r0 answered first (240), then r1 (160). `div_valid_out` pulses exactly twice.
- **Round-robin fairness.** Keep both slots refilled continuously for 8 responses → grant order 0,1,0,1,…; no requester is served twice in a row.
- **Divide by zero.** r1 sends 500/0 → `rsp_valid_out`=10 with `rsp_error_out`=1. A following r0 request, 7/2, returns quotient 3, remainder 1, error 0.
- **Reset mid-operation.** Issue 1000/8, then assert `rst_in` during WAIT → no response pulse; all outputs at reset values. A subsequent 1000/8 succeeds.
- **Timeout** (with `DIV_ARB_TIMEOUT_EN`, `TIMEOUT`=16). Hold `div_done_in` low after the issue → error response and `div_abort_out` pulse exactly 16 cycles after entering WAIT.
